// File: rtl/radix2_divider.sv
// radix2_divider
//   Sequential radix-2 restoring divider, signed or unsigned, one quotient
//   bit per clock. The operand magnitudes are divided and the signs are
//   applied in a single fix-up cycle afterwards. Divide-by-zero and signed
//   overflow bypass the iteration and finish one cycle after start.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request a new division (looked at only while idle)
//   flush      synchronous abort to idle, wins over start
//   is_signed  1: two's-complement division, 0: unsigned
//   opa, opb   dividend / divisor, captured when start is accepted
//   quotient   registered quotient, held until the next result
//   remainder  registered remainder, held until the next result
//   busy       high whenever the unit is not idle
//   done       one-cycle pulse marking quotient/remainder valid
module radix2_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Control state
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  // Working registers. quo_q starts out holding the dividend magnitude;
  // its MSB feeds the partial remainder while quotient bits shift in at the
  // bottom, so after WIDTH steps it holds the quotient magnitude.
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  // Result registers, only written when a result is produced
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  // Operand decode at start
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             sgn_ovf;

  // One restoring step
  logic [WIDTH+1:0] shifted_d;
  logic [WIDTH+1:0] diff_d;
  logic             qbit_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;

  // Sign fix-up
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    a_neg    = is_signed & opa[WIDTH-1];
    b_neg    = is_signed & opb[WIDTH-1];
    a_mag    = a_neg ? -opa : opa;
    b_mag    = b_neg ? -opb : opb;
    div_zero = (opb == '0);
    sgn_ovf  = is_signed && (opa == {1'b1, {(WIDTH-1){1'b0}}}) && (opb == '1);
  end

  // The partial remainder is below the divisor (< 2^WIDTH), so the shifted
  // value fits WIDTH+1 bits; one extra bit on top catches the borrow.
  always_comb begin
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    diff_d    = shifted_d - {1'b0, dvs_q};
    qbit_d    = ~diff_d[WIDTH+1];
    rem_d     = qbit_d ? diff_d[WIDTH:0] : shifted_d[WIDTH:0];
    quo_d     = {quo_q[WIDTH-2:0], qbit_d};
  end

  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (flush) begin
      // Results are left untouched; only control returns to idle.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvs_q     <= {1'b0, b_mag};
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            busy_q    <= 1'b1;
            if (div_zero) begin
              quotient_q  <= '1;
              remainder_q <= opa;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else if (sgn_ovf) begin
              quotient_q  <= opa;
              remainder_q <= '0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        FIX: begin
          quotient_q  <= quo_fix;
          remainder_q <= rem_fix;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_radix2_divider.sv
module tb_radix2_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        flush;
  logic        is_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  logic        start8;
  logic        flush8;
  logic        sg8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        busy8;
  logic        done8;

  int checks = 0;
  int errors = 0;

  radix2_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .is_signed (is_signed),
    .opa       (opa),
    .opb       (opb),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  radix2_divider #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .flush     (flush8),
    .is_signed (sg8),
    .opa       (a8),
    .opb       (b8),
    .quotient  (q8),
    .remainder (r8),
    .busy      (busy8),
    .done      (done8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start one 32-bit division; lat = negedges from accept until done is seen
  // (0 if it never comes), bcnt = cycles busy before the done cycle.
  task automatic run32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    is_signed = sg;
    opa       = a;
    opb       = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic op32(input string tag, input logic sg, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eq,
                      input logic [31:0] er, input int elat);
    int lat;
    int bcnt;
    run32(sg, a, b, lat, bcnt);
    check_eq({tag, ".lat"}, lat, elat);
    check_eq({tag, ".q"}, quotient, eq);
    check_eq({tag, ".r"}, remainder, er);
    @(negedge clk);
    check_eq({tag, ".pulse"}, done, 1'b0);
    check_eq({tag, ".idle"}, busy, 1'b0);
  endtask

  task automatic op8(input string tag, input logic sg, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eq,
                     input logic [7:0] er, input int elat);
    int lat;
    @(negedge clk);
    sg8    = sg;
    a8     = a;
    b8     = b;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done8) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, ".lat"}, lat, elat);
    check_eq({tag, ".q"}, q8, eq);
    check_eq({tag, ".r"}, r8, er);
    @(negedge clk);
    check_eq({tag, ".pulse"}, done8, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bcnt;
    int pulses;
    int first;
    int second;
    logic [31:0] qmid;

    rst       = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    opa       = '0;
    opb       = '0;
    start8    = 1'b0;
    flush8    = 1'b0;
    sg8       = 1'b0;
    a8        = '0;
    b8        = '0;

    #12;
    check_eq("rst.q", quotient, 32'h0);
    check_eq("rst.r", remainder, 32'h0);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7 unsigned, with latency and busy length
    run32(1'b0, 32'd100, 32'd7, lat, bcnt);
    check_eq("u100_7.lat", lat, 34);
    check_eq("u100_7.busy", bcnt, 33);
    check_eq("u100_7.q", quotient, 32'd14);
    check_eq("u100_7.r", remainder, 32'd2);
    @(negedge clk);
    check_eq("u100_7.pulse", done, 1'b0);
    check_eq("u100_7.idle", busy, 1'b0);

    op32("s-7_2",  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    op32("u-7_2",  1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'h00000001, 34);
    op32("s7_-2",  1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 34);
    op32("s-7_-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 34);
    op32("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 34);
    op32("udz",    1'b0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1);
    op32("sdz",    1'b1, 32'h80000001, 32'd0,        32'hFFFFFFFF, 32'h80000001, 1);
    op32("sovf",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1);
    op32("uovf",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);

    // start pulsed again at cycle 10 with other operands
    @(negedge clk);
    is_signed = 1'b0;
    opa       = 32'd1000;
    opb       = 32'd10;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    first  = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 10) begin
        start     = 1'b1;
        opa       = 32'd55;
        opb       = 32'd5;
        is_signed = 1'b1;
      end
      if (n == 11) start = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    check_eq("rebusy.pulses", pulses, 1);
    check_eq("rebusy.lat", first, 34);
    check_eq("rebusy.q", quotient, 32'd100);
    check_eq("rebusy.r", remainder, 32'd0);

    // flush at cycle 5 of CALC
    @(negedge clk);
    is_signed = 1'b0;
    opa       = 32'd500;
    opb       = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush.busy", busy, 1'b0);
    check_eq("flush.q", quotient, 32'd100);
    check_eq("flush.r", remainder, 32'd0);
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("flush.nodone", pulses, 0);
    op32("u20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 34);

    // flush and start together in IDLE
    @(negedge clk);
    opa   = 32'd9;
    opb   = 32'd3;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check_eq("flst.busy", busy, 1'b0);
    @(negedge clk);
    check_eq("flst.busy2", busy, 1'b0);
    check_eq("flst.q", quotient, 32'd6);

    // rst in the middle of CALC
    @(negedge clk);
    opa   = 32'd1000;
    opb   = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 8; n++) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst.q", quotient, 32'h0);
    check_eq("midrst.r", remainder, 32'h0);
    check_eq("midrst.busy", busy, 1'b0);
    check_eq("midrst.done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("midrst.nodone", pulses, 0);
    op32("u12345_100", 1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 34);

    // back-to-back: second start held from the done cycle on
    @(negedge clk);
    is_signed = 1'b0;
    opa       = 32'd100;
    opb       = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first  = 0;
    second = 0;
    qmid   = '0;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (done) begin
        if (first == 0) begin
          first     = n;
          is_signed = 1'b1;
          opa       = 32'd250;
          opb       = 32'd16;
          start     = 1'b1;
        end else if (second == 0) begin
          second = n;
        end
      end
      if (first != 0 && n == first + 2) start = 1'b0;
      if (n == 50) qmid = quotient;
      if (second != 0) break;
    end
    check_eq("b2b.first", first, 34);
    check_eq("b2b.second", second, 69);
    check_eq("b2b.hold", qmid, 32'd14);
    check_eq("b2b.q", quotient, 32'd15);
    check_eq("b2b.r", remainder, 32'd10);
    @(negedge clk);

    // 8-bit instance
    op8("w8.u81_3",  1'b0, 8'h81, 8'h03, 8'h2B, 8'h00, 10);
    op8("w8.s81_3",  1'b1, 8'h81, 8'h03, 8'hD6, 8'hFF, 10);
    op8("w8.dz",     1'b1, 8'h80, 8'h00, 8'hFF, 8'h80, 1);
    op8("w8.ovf",    1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
